// File: rtl/uart_pkg.sv
// Shared constants and sizing helpers for the UART receive-side buffer.
// Imported by the receive buffer top and its FIFO sub-module.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DEPTH     = 16;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rts_threshold_default(input int depth);
    return depth - 4;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Valid/ready byte stream from the receive buffer to the serial-bus logic.
interface uart_rx_buffer_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic power-of-two synchronous FIFO with show-ahead read data.
// Write/read enables arrive already qualified by the owner.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_BITS = UART_DATA_BITS,
  parameter  int DEPTH     = UART_DEPTH,
  localparam int PTR_W     = ptr_w(DEPTH),
  localparam int ADDR_W    = PTR_W - 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [PTR_W-1:0]     count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]    wr_addr, rd_addr;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; only the pointers define
  // which entries are meaningful, and a reset here would turn RAM into flops.
  always_ff @(posedge clk_50m) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: edge-detects byte-ready, queues bytes, pulses the clear.
// Optional flow control output rts_n is built when UART_RXBUF_RTS_EN is defined.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int DATA_BITS     = UART_DATA_BITS,
  parameter  int DEPTH         = UART_DEPTH,
  parameter  int RTS_THRESHOLD = rts_threshold_default(DEPTH),
  localparam int CNT_W         = ptr_w(DEPTH)
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready_clr,
  uart_rx_buffer_if.master     m_if,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 overflow,
  input  logic                 overflow_clr
`ifdef UART_RXBUF_RTS_EN
  ,
  output logic                 rts_n
`endif
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffer: DEPTH must be a power of two in 2..256");
  end
  if (RTS_THRESHOLD < 1 || RTS_THRESHOLD > DEPTH) begin : g_bad_rts
    $error("uart_rx_buffer: RTS_THRESHOLD must lie in 1..DEPTH");
  end

  logic rx_ready_q, rx_ready_d;
  logic rx_ready_clr_q, rx_ready_clr_d;
  logic overflow_q, overflow_d;
  logic push_evt, pop, wr_en, drop;
  logic empty;

  uart_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_50m (clk_50m),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (m_if.m_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  always_comb begin
    push_evt       = rx_ready && !rx_ready_q;
    pop            = !empty && m_if.m_ready;
    wr_en          = push_evt && (!full || pop);
    drop           = push_evt && full && !pop;
    rx_ready_d     = rx_ready;
    rx_ready_clr_d = push_evt;
    overflow_d     = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // NOTE: every registered update uses non-blocking assignment so all flops
  // sample the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rx_ready_q     <= 1'b1;
      rx_ready_clr_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rx_ready_q     <= rx_ready_d;
      rx_ready_clr_q <= rx_ready_clr_d;
      overflow_q     <= overflow_d;
    end
  end

  assign rx_ready_clr = rx_ready_clr_q;
  assign overflow     = overflow_q;
  assign m_if.m_valid = !empty;

`ifdef UART_RXBUF_RTS_EN
  localparam logic [CNT_W-1:0] RTS_LVL = CNT_W'(RTS_THRESHOLD);

  logic             rts_n_q, rts_n_d;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count + CNT_W'(wr_en) - CNT_W'(pop);
    rts_n_d    = (count_next >= RTS_LVL);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) rts_n_q <= 1'b0;
    else     rts_n_q <= rts_n_d;
  end

  assign rts_n = rts_n_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer (DEPTH 16); RTS checks run when UART_RXBUF_RTS_EN is defined.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;
  localparam int RTS   = 12;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_ready_clr;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       overflow_clr;
`ifdef UART_RXBUF_RTS_EN
  logic       rts_n;
`endif

  uart_rx_buffer_if #(.DATA_BITS(8)) m_if ();

  uart_rx_buffer #(.DATA_BITS(8), .DEPTH(DEPTH), .RTS_THRESHOLD(RTS)) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .m_if         (m_if),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef UART_RXBUF_RTS_EN
    ,
    .rts_n        (rts_n)
`endif
  );

  always #5 clk_50m = ~clk_50m;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check_rts(input string tag);
`ifdef UART_RXBUF_RTS_EN
    check(tag, {31'd0, rts_n}, {31'd0, exp_q.size() >= RTS});
`endif
  endtask

  // Single rx_ready pulse; model accepts it only if the FIFO has room.
  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    step();
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    check("push_clr", {31'd0, rx_ready_clr}, 32'd1);
    check("push_count", {27'd0, count}, exp_q.size());
    check("push_valid", {31'd0, m_if.m_valid}, 32'd1);
    check("push_head", {24'd0, m_if.m_data}, {24'd0, exp_q[0]});
    check_rts("push_rts");
    rx_ready = 1'b0;
    step();
    check("clr_one_cycle", {31'd0, rx_ready_clr}, 32'd0);
  endtask

  task automatic drain_one();
    logic [7:0] e;
    e = exp_q.pop_front();
    check("pop_valid", {31'd0, m_if.m_valid}, 32'd1);
    check("pop_data", {24'd0, m_if.m_data}, {24'd0, e});
    m_if.m_ready = 1'b1;
    step();
    m_if.m_ready = 1'b0;
    check("pop_count", {27'd0, count}, exp_q.size());
    check_rts("pop_rts");
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) drain_one();
    check("drained_valid", {31'd0, m_if.m_valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst          = 1'b1;
    rx_ready     = 1'b0;
    rx_data      = 8'h00;
    overflow_clr = 1'b0;
    m_if.m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_valid", {31'd0, m_if.m_valid}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_clr", {31'd0, rx_ready_clr}, 32'd0);
    check_rts("rst_rts");
    step();

    // m_ready while empty has no effect
    m_if.m_ready = 1'b1;
    step();
    m_if.m_ready = 1'b0;
    check("empty_pop_count", {27'd0, count}, 32'd0);

    // Single byte
    push_byte(8'hA5);
    drain_all();

    // Fill, overflow (set beats clear), sticky, clear, drain in order
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_overflow", {31'd0, overflow}, 32'd0);
    rx_data      = 8'h55;
    rx_ready     = 1'b1;
    overflow_clr = 1'b1;
    step();
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    check("ovf_clr_pulse", {31'd0, rx_ready_clr}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    rx_ready     = 1'b0;
    overflow_clr = 1'b0;
    step();
    step();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    check("ovf_head_stable", {24'd0, m_if.m_data}, 32'h00);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    drain_all();

    // Push and pop together while full
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h10 + i));
    check("sim_head", {24'd0, m_if.m_data}, {24'd0, exp_q.pop_front()});
    rx_data      = 8'h77;
    rx_ready     = 1'b1;
    m_if.m_ready = 1'b1;
    step();
    exp_q.push_back(8'h77);
    rx_ready     = 1'b0;
    m_if.m_ready = 1'b0;
    check("sim_overflow", {31'd0, overflow}, 32'd0);
    check("sim_count", {27'd0, count}, 32'd16);
    check("sim_full", {31'd0, full}, 32'd1);
    check("sim_clr", {31'd0, rx_ready_clr}, 32'd1);
    step();
    drain_all();

    // Push and pop together while empty: pop is a no-op
    rx_data      = 8'h3C;
    rx_ready     = 1'b1;
    m_if.m_ready = 1'b1;
    step();
    exp_q.push_back(8'h3C);
    rx_ready     = 1'b0;
    m_if.m_ready = 1'b0;
    check("empty_sim_count", {27'd0, count}, 32'd1);
    step();
    drain_all();

    // Level held high for 40 cycles gives one push
    pulses   = 0;
    rx_data  = 8'hC3;
    rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rx_ready_clr) pulses++;
    end
    exp_q.push_back(8'hC3);
    check("hold_pulses", pulses, 32'd1);
    check("hold_count", {27'd0, count}, 32'd1);
    rx_ready = 1'b0;
    step();
    drain_all();

    // Reset mid-stream with rx_ready high
    for (int i = 0; i < 5; i++) push_byte(8'(8'hE0 + i));
    rx_ready = 1'b1;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", {27'd0, count}, 32'd0);
    check("mid_rst_valid", {31'd0, m_if.m_valid}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("mid_rst_no_capture", {27'd0, count}, 32'd0);
    check("mid_rst_no_clr", {31'd0, rx_ready_clr}, 32'd0);
    rx_ready = 1'b0;
    step();
    push_byte(8'h99);
    drain_all();

`ifdef UART_RXBUF_RTS_EN
    // rts_n tracks fill level against the threshold
    for (int i = 0; i < RTS; i++) push_byte(8'(8'h40 + i));
    check("rts_at_thresh", {31'd0, rts_n}, 32'd1);
    drain_one();
    check("rts_below", {31'd0, rts_n}, 32'd0);
    drain_all();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It detects each new-byte event from the receiver, captures the byte into a power-of-two FIFO and pulses the receiver's clear input. Queued bytes are presented to the serial-bus logic on a valid/ready stream. Overflow is reported as a sticky flag.

Parameters:
DATA_BITS, 8, byte width; must equal the receiver's DATA_BITS
DEPTH, 16, FIFO entries; power of two, 2..256
RTS_THRESHOLD, DEPTH-4, fill level at or above which rts_n deasserts (only with UART_RXBUF_RTS_EN)

Ports:
clk_50m  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
rx_ready  in  1  receiver byte-ready level
rx_data  in  DATA_BITS  receiver byte; stable while rx_ready is high
rx_ready_clr  out  1  one-cycle pulse to the receiver's clear input
m_data  out  DATA_BITS  head-of-FIFO byte
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
count  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
full  out  1  count == DEPTH
overflow  out  1  sticky: a byte was dropped
overflow_clr  in  1  clears overflow
rts_n  out  1  flow control, active-low; present only with UART_RXBUF_RTS_EN

Behaviour:
- Reset (rst high at clock edge): wr_ptr, rd_ptr, count = 0; m_valid = 0; full = 0; overflow = 0; rx_ready_clr = 0; rx_ready_q = 1; rts_n = 0. Memory contents are don't-care.
- Push event: rx_ready && !rx_ready_q, a rising edge against a registered copy. Because rx_ready_q resets to 1, a ready level already high at reset release is ignored.
- On a push event at edge N:
  - if not full, or a pop happens in the same cycle: rx_data is written at wr_ptr and wr_ptr increments.
  - otherwise the byte is dropped and overflow is set.
  - rx_ready_clr = 1 for exactly the cycle after edge N, whether the byte was written or dropped.
- Pop: m_valid && m_ready. rd_ptr increments.
- Read timing: m_data = mem[rd_ptr], combinational from registered pointer (show-ahead). A byte pushed at edge N is visible with m_valid = 1 from cycle N+1. Push-to-output latency is 1 cycle.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - empty = pointers equal
  - full = addresses equal and MSBs differ
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1)
- Simultaneous push and pop:
  - count unchanged
  - allowed when full, no overflow
  - allowed when empty, and the pop is a no-op because m_valid = 0; count becomes 1
- m_ready while empty: no effect.
- overflow_clr together with a new overflow in the same cycle: set wins.
- m_data is stable while m_valid && !m_ready.
- No state machine beyond the edge detector and the clr pulse register. All flags are registered or derived from registered pointers.

Optional Feature:
UART_RXBUF_RTS_EN
- Defined: the rts_n port exists and is registered. rts_n = 1 when the next-state count >= RTS_THRESHOLD, otherwise 0. Updates on the same edge as count. Reset value 0.
- Undefined: the rts_n port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package uart_pkg:
  - localparam functions for pointer width, $clog2(DEPTH)+1
  - default DATA_BITS constant
  - RTS threshold default
- One sub-module, uart_sync_fifo: generic pointer/memory/flag FIFO.
- uart_rx_buffer owns the edge detect, clr pulse, overflow and RTS logic around uart_sync_fifo.

Test Plan:
1. Reset, then rx_ready pulses with rx_data 0xA5, m_ready = 0 → cycle N+1: m_valid = 1, m_data = 0xA5, count = 1, one rx_ready_clr pulse.
2. Push 0x00..0x0F (DEPTH = 16), m_ready = 0, then push 0x55 → full = 1, count = 16, overflow = 1, rx_ready_clr still pulses. Drain yields 0x00..0x0F in order; 0x55 never appears.
3. Full FIFO; push 0x77 and pop in the same cycle → overflow stays 0, count = 16, last byte drained = 0x77.
4. rx_ready held high for 40 cycles → exactly one push, count = 1.
5. rst asserted mid-stream with count = 5 and rx_ready high → after reset count = 0, m_valid = 0, overflow = 0, no capture until rx_ready falls and rises again.
6. UART_RXBUF_RTS_EN defined, RTS_THRESHOLD = 12 → rts_n rises on the edge count reaches 12. Pop one byte → rts_n = 0 on that edge.
